// File: rtl/reg_file_8x16.sv
// Eight-entry register file: R0 hard-wired to zero, two bypassed combinational
// read ports, a raw debug read port and a wrapping committed-write counter.
module reg_file_8x16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [2:0]       wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [2:0]       ra1,
    output logic [WIDTH-1:0] rd1,
    input  logic [2:0]       ra2,
    output logic [WIDTH-1:0] rd2,
    input  logic [2:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_out,
    output logic [7:0]       wr_count
);

    logic [WIDTH-1:0] regs_r [1:7];
    logic [WIDTH-1:0] view_s [8];
    logic [7:0]       wr_count_r;
    logic             commit_s;

    // a write only counts when it targets a real register
    assign commit_s = we && (wa != 3'd0);

    // register storage, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 8; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (commit_s) begin
            regs_r[wa] <= wd;
        end else begin
            for (int i = 1; i < 8; i++) begin
                regs_r[i] <= regs_r[i];
            end
        end
    end

    // committed-write counter, wraps naturally at 8 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_r <= 8'd0;
        end else if (commit_s) begin
            wr_count_r <= wr_count_r + 8'd1;
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    // address-indexed view of storage with R0 tied to zero
    always_comb begin
        view_s[0] = {WIDTH{1'b0}};
        for (int i = 1; i < 8; i++) begin
            view_s[i] = regs_r[i];
        end
    end

    // read port 1 with same-cycle write bypass (commit_s excludes R0)
    always_comb begin
        rd1 = {WIDTH{1'b0}};
        if (commit_s && (ra1 == wa)) begin
            rd1 = wd;
        end else begin
            rd1 = view_s[ra1];
        end
    end

    // read port 2 with same-cycle write bypass
    always_comb begin
        rd2 = {WIDTH{1'b0}};
        if (commit_s && (ra2 == wa)) begin
            rd2 = wd;
        end else begin
            rd2 = view_s[ra2];
        end
    end

    assign dbg_out  = view_s[dbg_sel];
    assign wr_count = wr_count_r;

endmodule

// File: tb/tb_reg_file_8x16.sv
// Directed bench for reg_file_8x16: expected outputs come from a small
// reference model, queued at drive time and compared at sample time.
module tb_reg_file_8x16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         we;
    logic [2:0]   wa;
    logic [W-1:0] wd;
    logic [2:0]   ra1;
    logic [2:0]   ra2;
    logic [2:0]   dbg_sel;
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic [W-1:0] dbg_out;
    logic [7:0]   wr_count;

    typedef struct packed {
        logic [W-1:0] rd1;
        logic [W-1:0] rd2;
        logic [W-1:0] dbg;
        logic [7:0]   cnt;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] mdl [8];
    logic [7:0]   mdl_cnt;
    int           vectors = 0;
    int           miscompares = 0;

    reg_file_8x16 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .ra1      (ra1),
        .rd1      (rd1),
        .ra2      (ra2),
        .rd2      (rd2),
        .dbg_sel  (dbg_sel),
        .dbg_out  (dbg_out),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    // reference storage: cleared by reset, updated on committed writes
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mdl[i] <= '0;
            mdl_cnt <= 8'd0;
        end else if (we === 1'b1 && wa != 3'd0) begin
            mdl[wa] <= wd;
            mdl_cnt <= mdl_cnt + 8'd1;
        end
    end

    function automatic exp_t model_out();
        exp_t e;
        logic byp;
        byp   = (we === 1'b1) && (wa != 3'd0);
        e.rd1 = (byp && ra1 == wa) ? wd : mdl[ra1];
        e.rd2 = (byp && ra2 == wa) ? wd : mdl[ra2];
        e.dbg = mdl[dbg_sel];
        e.cnt = mdl_cnt;
        return e;
    endfunction

    task automatic cmp(input string tag, input string fld,
                       input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s got %h want %h", tag, fld, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [2:0] a, input logic [W-1:0] d,
                         input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] ds);
        we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; dbg_sel = ds;
    endtask

    task automatic check(input string tag);
        exp_t e;
        sb_q.push_back(model_out());
        #1;
        e = sb_q.pop_front();
        cmp(tag, "rd1", rd1, e.rd1);
        cmp(tag, "rd2", rd2, e.rd2);
        cmp(tag, "dbg", dbg_out, e.dbg);
        cmp(tag, "cnt", {8'd0, wr_count}, {8'd0, e.cnt});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 3'd0, '0, 3'd0, 3'd0, 3'd0);
        #1 rst_n = 1'b0;
        #1;
        check("reset");
        // bypass stays live in reset, but the edge must not commit
        drive(1'b1, 3'd2, 16'hABCD, 3'd2, 3'd0, 3'd2);
        check("rst_bypass");
        tick();
        drive(1'b0, 3'd0, '0, 3'd2, 3'd2, 3'd2);
        check("rst_lost");
        rst_n = 1'b1;

        drive(1'b1, 3'd3, 16'h1234, 3'd0, 3'd0, 3'd3);
        check("wr3_pre");
        tick();
        drive(1'b0, 3'd0, '0, 3'd3, 3'd3, 3'd3);
        check("wr3_post");
        cmp("wr3_const", "rd1", rd1, 16'h1234);
        cmp("wr3_const", "cnt", {8'd0, wr_count}, 16'd1);

        drive(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 3'd0);
        check("r0_pre");
        tick();
        check("r0_post");
        cmp("r0_const", "cnt", {8'd0, wr_count}, 16'd1);

        drive(1'b1, 3'd5, 16'h00AA, 3'd0, 3'd0, 3'd0);
        tick();
        drive(1'b1, 3'd5, 16'h5555, 3'd5, 3'd1, 3'd5);
        check("byp5_pre");
        cmp("byp5_const", "dbg", dbg_out, 16'h00AA);
        tick();
        drive(1'b0, 3'd0, '0, 3'd5, 3'd5, 3'd5);
        check("byp5_post");
        cmp("byp5_const", "dbg_post", dbg_out, 16'h5555);

        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 3'(i), W'(16'h1111 * i), 3'd0, 3'd0, 3'd0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, '0, 3'(i), 3'(7 - i), 3'(i));
            check($sformatf("sweep%0d", i));
            cmp("sweep_const", "rd1", rd1, W'(16'h1111 * i));
            tick();
        end
        drive(1'b0, 3'd0, '0, 3'd4, 3'd4, 3'd4);
        check("same_reg");

        drive(1'b1, 3'd2, 16'h7777, 3'd0, 3'd0, 3'd0);
        tick();
        drive(1'b0, 3'd0, '0, 3'd1, 3'd7, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst");
        cmp("async_const", "cnt", {8'd0, wr_count}, 16'd0);
        tick();
        drive(1'b1, 3'd6, 16'hBEEF, 3'd6, 3'd0, 3'd6);
        check("rst_wr_pre");
        tick();
        drive(1'b0, 3'd0, '0, 3'd6, 3'd6, 3'd6);
        check("rst_wr_lost");
        rst_n = 1'b1;
        drive(1'b1, 3'd6, 16'hBEEF, 3'd0, 3'd0, 3'd6);
        check("first_wr_pre");
        tick();
        drive(1'b0, 3'd0, '0, 3'd6, 3'd6, 3'd6);
        check("first_wr_post");

        // 255 more writes bring the count to 256 since reset
        for (int i = 0; i < 255; i++) begin
            drive(1'b1, 3'(1 + i % 7), W'($urandom), 3'(i % 8), 3'((i + 3) % 8), 3'((i + 5) % 8));
            check("bulk");
            tick();
        end
        drive(1'b0, 3'd0, '0, 3'd0, 3'd0, 3'd0);
        check("wrap");
        cmp("wrap_const", "cnt", {8'd0, wr_count}, 16'd0);
        drive(1'b1, 3'd7, 16'h0F0F, 3'd7, 3'd7, 3'd7);
        tick();
        drive(1'b0, 3'd0, '0, 3'd7, 3'd7, 3'd7);
        check("wrap_plus1");
        cmp("wrap1_const", "cnt", {8'd0, wr_count}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
